// File: rtl/carpark_gate_if.sv
// Lane-side signal bundle for the car park gate controller.
// master drives sensors/keypad; slave is the controller.
interface carpark_gate_if #(
   parameter int CW = 4
);
   logic          entry_req;
   logic          exit_req;
   logic [1:0]    password;
   logic          pw_valid;
   logic          car_passed;
   logic          gate_open;
   logic          entry_grant;
   logic          exit_grant;
   logic          full;
   logic          alarm;
   logic [CW-1:0] occupancy;

   modport master (
      output entry_req, exit_req, password,
      output pw_valid, car_passed,
      input  gate_open, entry_grant, exit_grant,
      input  full, alarm, occupancy
   );

   modport slave (
      input  entry_req, exit_req, password,
      input  pw_valid, car_passed,
      output gate_open, entry_grant, exit_grant,
      output full, alarm, occupancy
   );
endinterface

// File: rtl/carpark_gate_ctrl.sv
// Shared entry/exit barrier sequencer with password check,
// lockout, gate-open timeout and occupancy tracking.
module carpark_gate_ctrl #(
   parameter int         CAPACITY  = 8,
   parameter int         CW        = 4,
   parameter logic [1:0] CODE      = 2'b10,
   parameter int         MAX_TRIES = 3,
   parameter int         GATE_TIME = 16,
   parameter int         LOCK_TIME = 32
) (
   input logic            clock,
   input logic            reset,
   carpark_gate_if.slave  bus
);
   localparam int GW  = $clog2(GATE_TIME + 1);
   localparam int LW  = $clog2(LOCK_TIME + 1);
   localparam int TRW = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, OPEN_IN, OPEN_OUT, LOCK
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   occ_q, occ_d;
   logic [TRW-1:0]  tries_q, tries_d;
   logic [GW-1:0]   gtmr_q, gtmr_d;
   logic [LW-1:0]   ltmr_q, ltmr_d;
   logic            last_exit_q, last_exit_d;
   logic            full_w;
   logic            ent_ok;
   logic [TRW-1:0]  tries_inc;

   assign full_w    = (occ_q == CW'(CAPACITY));
   assign ent_ok    = bus.entry_req && !full_w;
   assign tries_inc = tries_q + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         occ_q       <= '0;
         tries_q     <= '0;
         gtmr_q      <= '0;
         ltmr_q      <= '0;
         last_exit_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         tries_q     <= tries_d;
         gtmr_q      <= gtmr_d;
         ltmr_q      <= ltmr_d;
         last_exit_q <= last_exit_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      occ_d       = occ_q;
      tries_d     = tries_q;
      last_exit_d = last_exit_q;
      // Timers run only while resident, so they restart at 0 on entry
      gtmr_d = (state_q == OPEN_IN || state_q == OPEN_OUT)
               ? gtmr_q + 1'b1 : '0;
      ltmr_d = (state_q == LOCK) ? ltmr_q + 1'b1 : '0;
      unique case (state_q)
         IDLE: begin
            if (ent_ok && (!bus.exit_req || last_exit_q)) begin
               state_d     = CHECK;
               last_exit_d = 1'b0;
            end else if (bus.exit_req) begin
               state_d     = OPEN_OUT;
               last_exit_d = 1'b1;
            end
         end
         CHECK: begin
            if (bus.pw_valid) begin
               if (bus.password == CODE) begin
                  state_d = OPEN_IN;
                  tries_d = '0;
               end else begin
                  tries_d = tries_inc;
                  if (tries_inc == TRW'(MAX_TRIES))
                     state_d = LOCK;
               end
            end else if (!bus.entry_req) begin
               state_d = IDLE;
            end
         end
         OPEN_IN: begin
            if (bus.car_passed) begin
               state_d = IDLE;
               if (!full_w) occ_d = occ_q + 1'b1;
            end else if (gtmr_q == GW'(GATE_TIME - 1)) begin
               state_d = IDLE;
            end
         end
         OPEN_OUT: begin
            if (bus.car_passed) begin
               state_d = IDLE;
               if (occ_q != '0) occ_d = occ_q - 1'b1;
            end else if (gtmr_q == GW'(GATE_TIME - 1)) begin
               state_d = IDLE;
            end
         end
         LOCK: begin
            if (ltmr_q == LW'(LOCK_TIME - 1)) begin
               state_d = IDLE;
               tries_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.entry_grant = (state_q == CHECK) || (state_q == OPEN_IN);
      bus.exit_grant  = (state_q == OPEN_OUT);
      bus.gate_open   = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
      bus.alarm       = (state_q == LOCK);
      bus.full        = full_w;
      bus.occupancy   = occ_q;
   end
endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// Randomized bench for carpark_gate_ctrl against a
// countdown-based behavioural model of the lane rules.
module tb_carpark_gate_ctrl;
   localparam int CAP = 8;
   localparam int GT  = 16;
   localparam int LT  = 32;
   localparam int MT  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   carpark_gate_if #(.CW(4)) bus ();

   carpark_gate_ctrl #(
      .CAPACITY (CAP),
      .CW       (4),
      .CODE     (2'b10),
      .MAX_TRIES(MT),
      .GATE_TIME(GT),
      .LOCK_TIME(LT)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus.slave)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag,
                      input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 password wait, 2 in, 3 out, 4 locked
   int m_mode, m_left, m_cars, m_fails;
   bit m_entry_turn;

   function automatic void m_reset();
      m_mode = 0; m_left = 0; m_cars = 0;
      m_fails = 0; m_entry_turn = 1'b1;
   endfunction

   function automatic void m_step(bit er, bit xr, bit pv,
                                  int pw, bit cp);
      case (m_mode)
         0: begin
            bit can_in;
            can_in = er && (m_cars < CAP);
            if (can_in && (!xr || m_entry_turn)) begin
               m_mode = 1; m_entry_turn = 1'b0;
            end else if (xr) begin
               m_mode = 3; m_left = GT; m_entry_turn = 1'b1;
            end
         end
         1: begin
            if (pv) begin
               if (pw == 2) begin
                  m_mode = 2; m_left = GT; m_fails = 0;
               end else begin
                  m_fails++;
                  if (m_fails >= MT) begin
                     m_mode = 4; m_left = LT;
                  end
               end
            end else if (!er) m_mode = 0;
         end
         2, 3: begin
            if (cp) begin
               if (m_mode == 2) m_cars++;
               else if (m_cars > 0) m_cars--;
               m_mode = 0;
            end else begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         end
         4: begin
            m_left--;
            if (m_left == 0) begin
               m_mode = 0; m_fails = 0;
            end
         end
         default: m_mode = 0;
      endcase
   endfunction

   task automatic compare_all();
      chk("gate_open", int'(bus.gate_open),
          int'(m_mode == 2 || m_mode == 3));
      chk("entry_grant", int'(bus.entry_grant),
          int'(m_mode == 1 || m_mode == 2));
      chk("exit_grant", int'(bus.exit_grant), int'(m_mode == 3));
      chk("alarm", int'(bus.alarm), int'(m_mode == 4));
      chk("full", int'(bus.full), int'(m_cars == CAP));
      chk("occupancy", int'(bus.occupancy), m_cars);
   endtask

   // Per phase: entry%, exit%, pw_valid%, good code%, car_passed%
   int prof [5][5] = '{
      '{70, 70, 40, 60, 30},
      '{90, 10, 50, 90, 40},
      '{60, 60, 50, 10, 20},
      '{50, 50, 30, 70, 3},
      '{70, 70, 40, 60, 30}
   };

   initial begin
      rst = 1'b1;
      bus.entry_req = 0; bus.exit_req = 0;
      bus.password = '0; bus.pw_valid = 0; bus.car_passed = 0;
      repeat (2) @(posedge clk);
      m_reset();
      #1 compare_all();
      @(negedge clk);
      rst = 1'b0;
      for (int ph = 0; ph < 5; ph++) begin
         for (int i = 0; i < 2000; i++) begin
            int pw;
            @(negedge clk);
            bus.entry_req  = ($urandom % 100) < prof[ph][0];
            bus.exit_req   = ($urandom % 100) < prof[ph][1];
            bus.pw_valid   = ($urandom % 100) < prof[ph][2];
            if (($urandom % 100) < prof[ph][3]) pw = 2;
            else begin
               pw = $urandom % 3;
               if (pw == 2) pw = 3;
            end
            bus.password   = 2'(pw);
            bus.car_passed = ($urandom % 100) < prof[ph][4];
            rst = (ph > 0) && (($urandom % 400) == 0);
            @(posedge clk);
            if (rst) m_reset();
            else m_step(bus.entry_req, bus.exit_req,
                        bus.pw_valid, pw, bus.car_passed);
            #1 compare_all();
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule

// File: doc/carpark_gate_ctrl.md
# carpark_gate_ctrl

Single-gate car park controller that sequences the shared barrier between an entry lane and an exit lane. It arbitrates simultaneous entry/exit requests, runs the 2-bit password check for entering cars with a retry limit and lockout, times the gate-open window, and tracks occupancy against capacity. It sits between the lane sensors/keypad and the barrier actuator.

## Interface
- CAPACITY, 8: maximum parked cars; entry refused when occupancy equals CAPACITY
- CW, 4: occupancy width; must satisfy 2^CW > CAPACITY
- CODE, 2'b10: correct entry password
- MAX_TRIES, 3: wrong passwords allowed before lockout
- GATE_TIME, 16: maximum cycles the gate stays open
- LOCK_TIME, 32: lockout duration in cycles

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- entry_req  in  1  car waiting at entry (level)
- exit_req  in  1  car waiting at exit (level)
- password  in  2  keypad code, sampled only when pw_valid=1
- pw_valid  in  1  one-cycle strobe: password is valid
- car_passed  in  1  one-cycle pulse from the gate sensor
- gate_open  out  1  barrier open command
- entry_grant  out  1  entry lane owns the gate
- exit_grant  out  1  exit lane owns the gate
- full  out  1  occupancy == CAPACITY
- occupancy  out  CW  current car count
- alarm  out  1  high throughout lockout

## Operation
- States: IDLE, CHECK, OPEN_IN, OPEN_OUT, LOCK. Reset -> IDLE.
- Outputs are Moore, decoded from registered state/counters: entry_grant = CHECK or OPEN_IN; exit_grant = OPEN_OUT; gate_open = OPEN_IN or OPEN_OUT; alarm = LOCK; full = (occupancy == CAPACITY).
- IDLE arbitration, entry eligible only when entry_req=1 and full=0:
  - only entry eligible -> CHECK; only exit_req -> OPEN_OUT.
  - both: round-robin via last_served bit (reset = exit, so entry wins the first contest); serve the lane not served last; update last_served on every grant.
  - full=1 with both requesting -> OPEN_OUT; last_served still updates.
- CHECK:
  - pw_valid=1 with password==CODE -> OPEN_IN; tries cleared.
  - pw_valid=1 with wrong password -> tries+1; if tries+1 == MAX_TRIES -> LOCK, else stay CHECK.
  - entry_req=0 with pw_valid=0 -> IDLE; tries retained (cleared only by correct code, lockout end, or reset).
  - pw_valid and entry_req=0 in same cycle: password evaluated, pw_valid wins.
  - exit_req ignored while in CHECK.
- OPEN_IN / OPEN_OUT:
  - gate timer cleared on entry to the state, increments each cycle.
  - car_passed=1 -> IDLE next cycle; occupancy +1 (OPEN_IN) or −1 (OPEN_OUT).
  - timer == GATE_TIME−1 with no car_passed -> IDLE; occupancy unchanged.
  - car_passed on the expiry cycle counts as a pass.
- Occupancy saturates: decrement at 0 holds 0, and the exit gate still opens; increment at CAPACITY cannot occur because entry is gated by full.
- LOCK: ignores all inputs for exactly LOCK_TIME cycles, then IDLE with tries=0.
- car_passed and pw_valid are ignored in any state where not listed.

## Timing
- Reset values: state IDLE, occupancy 0, tries 0, timers 0, last_served = exit; gate_open=0, entry_grant=0, exit_grant=0, full=0, alarm=0.
- Reset mid-operation (any state) returns to IDLE next edge and clears occupancy.
- IDLE request sampled at edge N -> grant (and gate_open for exit) high from cycle N+1.
- Correct pw_valid at edge N -> gate_open high from N+1.
- Gate open at most GATE_TIME cycles; car_passed at edge N -> gate_open low and occupancy updated from N+1; full follows occupancy in the same cycle.
- Third wrong code at edge N (MAX_TRIES=3) -> alarm high cycles N+1 through N+LOCK_TIME; IDLE at N+LOCK_TIME+1.
- Minimum one IDLE cycle between consecutive gate grants.

## Test plan
- Reset, entry_req=1, pw_valid with 2'b10, car_passed 3 cycles later -> entry_grant next cycle, gate_open 1 cycle after pw strobe, occupancy 0->1, return to IDLE.
- entry_req and exit_req both held from reset -> grants alternate entry, exit, entry…; each gate window ends on car_passed.
- Three wrong codes (2'b00, 2'b01, 2'b11) -> alarm high exactly 32 cycles, requests ignored during lockout, IDLE with tries=0 afterwards.
- Fill to 8 cars -> full=1; entry_req alone gets no grant; exit_req then gets OPEN_OUT, occupancy 8->7, full drops.
- Gate opened, no car_passed -> gate_open high exactly 16 cycles, occupancy unchanged; car_passed on cycle 16 -> counted.
- Exit at occupancy 0 -> gate opens, occupancy stays 0. Reset asserted mid OPEN_IN -> gate_open low and occupancy 0 next cycle.
